uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serial UART transmitter; the transmit-side counterpart of the project's UART receiver. It is driven by the same 16x oversampled baud clock BRclk. It accepts parallel bytes through a strobe/ready handshake, holds one byte in a holding register, and shifts frames out LSB-first on UART_TX. Framing is start bit, data, optional parity, then stop bit(s). The double buffer lets the host sustain back-to-back frames with no idle gap.

Parameters:
- OVERSAMPLE, 16: BRclk cycles per serial bit; must be ≥2.
- DATA_BITS, 8: data bits per frame, range 5..8.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.

Ports:
- BRclk  input  1: baud oversample clock; all logic on posedge.
- rst_n  input  1: asynchronous, active-low reset.
- TX_DATA  input  DATA_BITS: byte to send; sampled only on an accepted TX_EN.
- TX_EN  input  1: write strobe; accepted on a BRclk edge where TX_STATUS=1.
- TX_STATUS  output  1: ready; 1 means the holding register is empty and can accept a byte.
- TX_BUSY  output  1: 1 while a frame is on the line or a byte is pending.
- UART_TX  output  1: serial line, idles high; registered output.

Behaviour:
- Reset (async, rst_n=0):
  - UART_TX=1, TX_STATUS=1, TX_BUSY=0.
  - FSM=IDLE, counters=0, holding register invalid.
  - Reset mid-frame aborts the frame and the line returns high immediately. No partial frame resumes after release.
- Handshake:
  - TX_EN && TX_STATUS at edge N: TX_DATA is captured into the holding register and hold_valid=1. TX_STATUS reads 0 after edge N.
  - TX_EN while TX_STATUS=0 is ignored. There is no overwrite and no error flag.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - tick counter: 0..OVERSAMPLE-1.
  - bit counter: 0..DATA_BITS-1 in DATA; 0..STOP_BITS-1 in STOP.
- IDLE:
  - UART_TX=1.
  - If hold_valid, the next edge moves the holding register into the shifter, clears hold_valid, enters START, and resets tick to 0.
  - Latency: a byte accepted at edge N while IDLE drives UART_TX low from edge N+1.
- START:
  - UART_TX=0 for OVERSAMPLE cycles, then DATA.
- DATA:
  - UART_TX = shifter[0] for OVERSAMPLE cycles per bit; the shifter shifts right at each bit boundary.
  - After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - UART_TX = XOR of the frame's data bits, inverted when PARITY_ODD=1, for OVERSAMPLE cycles.
- STOP:
  - UART_TX=1 for STOP_BITS*OVERSAMPLE cycles.
  - At the final cycle: if hold_valid, go directly to START with the shifter reloaded (zero idle cycles); else go to IDLE.
- Frame length: OVERSAMPLE*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles. The default is 160 cycles.
- The holding register frees while the shifter runs. TX_STATUS returns to 1 on the edge that transfers the byte to the shifter. At that same edge TX_STATUS is still 0, so a new TX_EN is not accepted; it is accepted from the following edge.
- TX_BUSY = (state≠IDLE) || hold_valid, registered.
- Data bits above DATA_BITS are not present; TX_DATA width equals DATA_BITS.
- Counter widths are $clog2 of the respective range. Counters never wrap past their terminal value; the terminal value forces a state change.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE/START/DATA/PARITY/STOP);
  - the default OVERSAMPLE constant, shared with the receiver;
  - a parity(data, odd) function.
- Single module; no sub-module is warranted. The tick counter and bit counter live inline with the FSM.

Test Plan:
- Default params: TX_EN with 0x55 at idle → UART_TX low from the next edge for 16 cycles. Bits then follow 1,0,1,0,1,0,1,0 at 16 cycles each, then 16 cycles high. TX_BUSY=1 for 161 cycles total, counting from the accept edge.
- Back-to-back: 0xA5, then 0x3C as soon as TX_STATUS=1 → the second start bit begins exactly on the cycle after the first stop bit's last cycle. There are 320 contiguous frame cycles with no idle high gap, and both bytes decode correctly.
- Overrun: with a frame in flight and the holding register full (TX_STATUS=0), pulse TX_EN with 0xFF → ignored. Only the previously queued byte is sent, and TX_STATUS stays 0 until its transfer.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x00 → UART_TX=1 asynchronously and TX_STATUS=1, TX_BUSY=0. After release with no TX_EN, the line stays high for 200 cycles.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 → parity bit 1. With PARITY_ODD=1, 0x07 → parity bit 0. Frame length is 176 cycles.
- Loopback: UART_TX feeds the project's UART receiver on a shared BRclk; send 0x00, 0xFF, 0x81 → the receiver's data output reports each byte in order with one status pulse per frame.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   tx_state_e          : transmitter FSM state encoding
//   DEFAULT_OVERSAMPLE  : BRclk cycles per serial bit (shared with the receiver)
//   MAX_DATA_BITS       : widest supported data field
//   parity(data, odd)   : even parity of data, inverted when odd=1
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int MAX_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic parity(input logic [MAX_DATA_BITS-1:0] data,
                                  input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_transmitter
// Double-buffered serial UART transmitter on the 16x oversample clock BRclk.
// A byte written through the TX_EN/TX_STATUS handshake lands in a holding
// register, moves into the shifter when the line is free, and is sent as
// start bit, DATA_BITS data bits LSB-first, optional parity, stop bit(s).
//
// Ports
//   BRclk     in   oversample clock, everything on posedge
//   rst_n     in   asynchronous active-low reset
//   TX_DATA   in   byte to send, sampled only on an accepted write
//   TX_EN     in   write strobe
//   TX_STATUS out  ready: holding register empty
//   TX_BUSY   out  a frame is on the line or a byte is pending
//   UART_TX   out  serial line, idles high, registered
//   dbg_state out  current FSM state (observation only)
//
// Handshake: TX_EN is the valid, TX_STATUS is the ready. A transfer happens on
// exactly the BRclk edge where both are 1; TX_DATA is captured on that edge.
// TX_EN while TX_STATUS=0 has no effect at all. TX_STATUS only drops as the
// result of a transfer and only rises when the held byte moves to the shifter.
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 BRclk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_EN,
  output logic                 TX_STATUS,
  output logic                 TX_BUSY,
  output logic                 UART_TX,
  output tx_state_e            dbg_state
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_SEL   = (PARITY_ODD != 0);

  tx_state_e            state;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shifter;
  logic                 par_bit;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_valid;
  logic                 accept;

  // TX_STATUS is kept equal to !hold_valid, so accept can never coincide
  // with a hold-to-shifter transfer.
  assign accept    = TX_EN && TX_STATUS;
  assign dbg_state = state;

  always_ff @(posedge BRclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      par_bit    <= 1'b0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      UART_TX    <= 1'b1;
      TX_STATUS  <= 1'b1;
      TX_BUSY    <= 1'b0;
    end else begin
      // Busy in every state except a quiet IDLE; the two places that can
      // fall idle override this below.
      TX_BUSY <= 1'b1;

      if (accept) begin
        hold_reg   <= TX_DATA;
        hold_valid <= 1'b1;
        TX_STATUS  <= 1'b0;
      end

      case (state)
        IDLE: begin
          UART_TX <= 1'b1;
          if (hold_valid) begin
            shifter    <= hold_reg;
            par_bit    <= parity(MAX_DATA_BITS'(hold_reg), ODD_SEL);
            hold_valid <= 1'b0;
            TX_STATUS  <= 1'b1;
            tick       <= '0;
            bit_cnt    <= '0;
            state      <= START;
            UART_TX    <= 1'b0;
          end else begin
            TX_BUSY <= accept;
          end
        end

        START: begin
          if (tick == TICK_LAST) begin
            tick    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            UART_TX <= shifter[0];
          end else begin
            tick <= tick + 1'b1;
          end
        end

        DATA: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state   <= PARITY;
                UART_TX <= par_bit;
              end else begin
                state   <= STOP;
                UART_TX <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shifter <= shifter >> 1;
              // The line register must already show the bit that becomes
              // shifter[0] after this shift.
              UART_TX <= shifter[1];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        PARITY: begin
          if (tick == TICK_LAST) begin
            tick    <= '0;
            bit_cnt <= '0;
            state   <= STOP;
            UART_TX <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        STOP: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (hold_valid) begin
                // Back-to-back: next start bit follows the last stop cycle
                // with no idle cycle in between.
                shifter    <= hold_reg;
                par_bit    <= parity(MAX_DATA_BITS'(hold_reg), ODD_SEL);
                hold_valid <= 1'b0;
                TX_STATUS  <= 1'b1;
                state      <= START;
                UART_TX    <= 1'b0;
              end else begin
                state   <= IDLE;
                UART_TX <= 1'b1;
                TX_BUSY <= accept;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          tick    <= '0;
          bit_cnt <= '0;
          UART_TX <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Three transmitters on one BRclk: no parity, even parity, odd parity.
// Each has a frame-level reference model: an accepted byte waits in a pending
// slot, and whenever the line has nothing left to send the pending byte is
// expanded into its full per-cycle waveform. Line, ready and busy are compared
// every cycle. A line decoder on instance 0 checks bytes against exp_q.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int OS   = 16;
  localparam int NB   = 8;
  localparam int NDUT = 3;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [NB-1:0]   tx_data;
  logic [NDUT-1:0] tx_en;
  logic [NDUT-1:0] tx_status;
  logic [NDUT-1:0] tx_busy;
  logic [NDUT-1:0] uart_tx;
  logic [3*NDUT-1:0] dbg_bits;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  bit rx_en  = 1'b0;
  logic [NB-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- DUTs and reference models ----------------
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int PEN  = (g > 0) ? 1 : 0;
    localparam int PODD = (g == 2) ? 1 : 0;

    uart_transmitter #(
      .OVERSAMPLE(OS),
      .DATA_BITS (NB),
      .STOP_BITS (1),
      .PARITY_EN (PEN),
      .PARITY_ODD(PODD)
    ) u_dut (
      .BRclk    (clk),
      .rst_n    (rst_n),
      .TX_DATA  (tx_data),
      .TX_EN    (tx_en[g]),
      .TX_STATUS(tx_status[g]),
      .TX_BUSY  (tx_busy[g]),
      .UART_TX  (uart_tx[g]),
      .dbg_state(dbg_bits[3*g +: 3])
    );

    bit            wave_q[$];
    bit            pend_v = 1'b0;
    logic [NB-1:0] pend_b = '0;

    always @(posedge clk or negedge rst_n) begin
      bit syms[$];
      bit acc;
      if (!rst_n) begin
        wave_q.delete();
        pend_v = 1'b0;
      end else begin
        acc = tx_en[g] && !pend_v;
        if (wave_q.size() > 0) void'(wave_q.pop_front());
        if (wave_q.size() == 0 && pend_v) begin
          syms.delete();
          syms.push_back(1'b0);
          for (int b = 0; b < NB; b++) syms.push_back(pend_b[b]);
          if (PEN != 0) syms.push_back((($countones(pend_b) % 2) == 1) ^ (PODD == 1));
          syms.push_back(1'b1);
          foreach (syms[s]) repeat (OS) wave_q.push_back(syms[s]);
          pend_v = 1'b0;
        end
        if (acc) begin
          pend_b = tx_data;
          pend_v = 1'b1;
          if (g == 0) exp_q.push_back(tx_data);
        end
      end
    end

    always @(negedge clk) begin
      if (mon_en) begin
        check($sformatf("line%0d", g), 32'(uart_tx[g]),
              (wave_q.size() > 0) ? 32'(wave_q[0]) : 32'd1);
        check($sformatf("status%0d", g), 32'(tx_status[g]), 32'(!pend_v));
        check($sformatf("busy%0d", g), 32'(tx_busy[g]),
              32'((wave_q.size() > 0) || pend_v));
      end
    end
  end

  // ---------------- line decoder / scoreboard (instance 0) ----------------
  initial begin : rx_decoder
    logic [NB-1:0] b;
    forever begin
      @(negedge clk);
      if (rx_en && uart_tx[0] == 1'b0) begin
        repeat (OS/2 - 1) @(negedge clk);
        check("rx_start", 32'(uart_tx[0]), 32'd0);
        for (int k = 0; k < NB; k++) begin
          repeat (OS) @(negedge clk);
          b[k] = uart_tx[0];
        end
        repeat (OS) @(negedge clk);
        check("rx_stop", 32'(uart_tx[0]), 32'd1);
        if (exp_q.size() == 0) check("rx_extra_frame", 32'(exp_q.size()), 32'd1);
        else check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [NDUT-1:0] mask, input logic [NB-1:0] d);
    @(posedge clk); #1;
    tx_data = d;
    tx_en   = mask;
    @(posedge clk); #1;
    tx_en   = '0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_low(input int i, output int t);
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (uart_tx[i] == 1'b0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check($sformatf("timeout_low%0d", i), 32'(uart_tx[i]), 32'd0);
  endtask

  task automatic wait_ready(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (tx_status[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("timeout_ready%0d", i), 32'(tx_status[i]), 32'd1);
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (tx_busy == '0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("timeout_idle", 32'(tx_busy), 32'd0);
  endtask

  task automatic count_busy(input int i, output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx_busy[i]) n++;
      else break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int t0, t1, n, n1, tp, hi;
    rst_n   = 1'b1;
    tx_en   = '0;
    tx_data = '0;
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("reset_line%0d", i),   32'(uart_tx[i]),   32'd1);
      check($sformatf("reset_status%0d", i), 32'(tx_status[i]), 32'd1);
      check($sformatf("reset_busy%0d", i),   32'(tx_busy[i]),   32'd0);
      check($sformatf("reset_state%0d", i),  32'(dbg_bits[3*i +: 3]), 32'(IDLE));
    end
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame from idle: busy from accept edge through the stop bit.
    send(3'b001, 8'h55);
    count_busy(0, n);
    check("busy_len_55", 32'(n), 32'd161);

    // Back-to-back: second byte written as soon as ready returns.
    send(3'b001, 8'hA5);
    wait_low(0, t0);
    wait_ready(0);
    send(3'b001, 8'h3C);
    wait_idle(t1);
    check("b2b_span", 32'(t1 - t0), 32'd320);

    // Overrun: write while the holding register is full is dropped.
    send(3'b001, 8'h11);
    wait_low(0, t0);
    wait_ready(0);
    send(3'b001, 8'h22);
    send(3'b001, 8'hFF);
    @(negedge clk);
    check("ovr_status", 32'(tx_status[0]), 32'd0);
    wait_idle(t1);
    check("ovr_span", 32'(t1 - t0), 32'd320);

    // Parity: 0x07 has three ones -> even parity 1, odd parity 0.
    send(3'b110, 8'h07);
    fork
      count_busy(1, n1);
      begin
        wait_low(1, tp);
        repeat (OS*9 + OS/2) @(negedge clk);
        check("par_even", 32'(uart_tx[1]), 32'd1);
        check("par_odd",  32'(uart_tx[2]), 32'd0);
      end
    join
    check("busy_len_par", 32'(n1), 32'd177);
    wait_idle(t1);

    // Random traffic, including writes that land while not ready.
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      if ($urandom_range(0, 1) == 1) wait_ready(0);
      send(3'($urandom_range(1, 7)), 8'($urandom));
    end
    wait_idle(t1);
    repeat (20) @(negedge clk);
    check("rx_queue_empty", 32'(exp_q.size()), 32'd0);
    rx_en = 1'b0;

    // Reset in the middle of data bit 3 of 0x00.
    send(3'b001, 8'h00);
    wait_low(0, t0);
    repeat (OS*4 + OS/2) @(negedge clk);
    check("rst_pre_line", 32'(uart_tx[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_line",   32'(uart_tx[0]),   32'd1);
    check("rst_status", 32'(tx_status[0]), 32'd1);
    check("rst_busy",   32'(tx_busy[0]),   32'd0);
    check("rst_state",  32'(dbg_bits[2:0]), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx[0]) hi++;
    end
    check("idle_after_rst", 32'(hi), 32'd200);
    check("post_rst_status", 32'(tx_status[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
